// File: rtl/bit_serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop; start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one bit of a - b - bin resolved per clock, busy=1
// DONE  | done=1 for one cycle; start here begins the next operation at once
module bit_serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-2:0]   res_sr;   // bits already resolved; the MSB comes from d on the last edge
  logic [CW-1:0]  cnt;
  logic           br;
  logic           a_msb;
  logic           b_msb;

  logic           d;
  logic           br_next;

  assign d       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  // Sequencer, datapath shift and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[N-1];
            b_msb <= b[N-1];
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          br   <= br_next;
          a_sr <= {1'b0, a_sr[N-1:1]};
          b_sr <= {1'b0, b_sr[N-1:1]};
          if (N > 2) begin
            res_sr <= {d, res_sr[N-2:1]};
          end else begin
            res_sr <= d;
          end
          if (cnt == LAST) begin
            // Last bit: publish the full word including this edge's bit.
            diff  <= {d, res_sr};
            bout  <= br_next;
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor: expected results are queued at
// issue time and popped by a monitor on every done pulse.
module tb_bit_serial_subtractor;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks;
  int failures;
  logic [N+1:0] exp_q[$];   // {ovf, bout, diff}

  bit_serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (op_a),
    .b     (op_b),
    .bin   (op_bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic mbin);
    int ur;
    int sr;
    int sa;
    int sb;
    logic [N-1:0] md;
    logic mbout;
    logic movf;
    ur    = int'(ma) - int'(mb) - int'(mbin);
    sa    = $signed(ma);
    sb    = $signed(mb);
    sr    = sa - sb - int'(mbin);
    md    = N'(ur & ((1 << N) - 1));
    mbout = (ur < 0);
    movf  = (sr < -(1 << (N - 1))) || (sr > (1 << (N - 1)) - 1);
    return {movf, mbout, md};
  endfunction

  // Drive start for one edge (caller ensures busy=0); returns at the negedge after acceptance.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                       input bit expect_result);
    op_a   = ta;
    op_b   = tb;
    op_bin = tbin;
    start  = 1'b1;
    if (expect_result) exp_q.push_back(model(ta, tb, tbin));
    @(negedge clk);
    start  = 1'b0;
    op_a   = N'($urandom);
    op_b   = N'($urandom);
    op_bin = 1'($urandom);
  endtask

  // Wait for done starting j0 cycles after acceptance; checks busy and latency.
  task automatic wait_done(input int j0);
    int j;
    int busy_bad;
    j = j0;
    busy_bad = 0;
    while (!done && j < 4 * N) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      j++;
    end
    check("done_latency", j, N);
    check("busy_during_shift", busy_bad, 0);
    check("busy_low_at_done", int'(busy), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_diff"}, int'(diff), 0);
    check({tag, "_bout"}, int'(bout), 0);
    check({tag, "_ovf"},  int'(ovf),  0);
  endtask

  initial begin
    logic [N+1:0] e;
    int gap;
    int stray;
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    start  = 1'b1;
    op_a   = 8'h12;
    op_b   = 8'h34;
    op_bin = 1'b0;

    // Monitor: pop and compare on every done pulse.
    fork
      forever begin
        @(negedge clk);
        if (!rst && done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("diff", int'(diff), int'(e[N-1:0]));
            check("bout", int'(bout), int'(e[N]));
            check("ovf",  int'(ovf),  int'(e[N+1]));
          end
        end
      end
    join_none

    // Reset overrides start.
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check_reset_state("idle_after_reset");

    // T1..T3 directed values.
    issue(8'h50, 8'h20, 1'b0, 1'b1); wait_done(0);
    issue(8'h00, 8'h01, 1'b0, 1'b1); wait_done(0);
    issue(8'h05, 8'h05, 1'b1, 1'b1); wait_done(0);
    issue(8'h80, 8'h01, 1'b0, 1'b1); wait_done(0);
    issue(8'h7F, 8'hFF, 1'b0, 1'b1); wait_done(0);
    @(negedge clk);

    // T4: stray start while busy is ignored; back-to-back start in DONE.
    issue(8'h50, 8'h20, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    op_a  = 8'h11;
    op_b  = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3);
    check("t4_first_diff", int'(diff), 8'h30);
    issue(8'h11, 8'h01, 1'b0, 1'b1);
    for (int k = 0; k < N - 2; k++) begin
      check("t4_diff_hold", int'(diff), 8'h30);
      @(negedge clk);
    end
    wait_done(N - 2);

    // T5: reset mid-operation aborts without a done pulse.
    @(negedge clk);
    issue(8'h50, 8'h20, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("abort");
    stray = 0;
    repeat (N + 2) begin
      if (done) stray++;
      @(negedge clk);
    end
    check("abort_no_done", stray, 0);
    issue(8'h09, 8'h03, 1'b0, 1'b1); wait_done(0);

    // T6: random operands with random idle gaps (gap 0 = back-to-back).
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      issue(N'($urandom), N'($urandom), 1'($urandom), 1'b1);
      wait_done(0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
